// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Round-robin arbiter that funnels NREQ register-file write requesters into
//   a single registered write port, with read-after-write hazard flags and a
//   committed-write counter.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   req_valid  : per-requester write request (bit i = requester i)
//   req_addr   : packed destination addresses, requester i at [ADDR_W*i +: ADDR_W]
//   req_data   : packed write data, requester i at [DATA_W*i +: DATA_W]
//   req_ready  : per-requester grant, one-hot or zero, combinational
//   rf_we      : register-file write enable (registered)
//   rf_waddr   : register-file write address (registered)
//   rf_wdata   : register-file write data (registered, bit-exact)
//   rd_addr1/2 : register-file read addresses used for hazard detection
//   hazard1/2  : read address matches the write currently in flight
//   wr_count   : number of committed writes, wraps 255 -> 0
`timescale 1ns/1ps
module rf_write_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [7:0]               wr_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wr_count;

  logic              w_found;
  logic [PTR_W-1:0]  w_win_idx;
  logic [NREQ-1:0]   w_grant;
  logic              w_accept;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic [PTR_W-1:0]  w_ptr_next;

  // Round-robin search: first valid requester starting at r_ptr, wrapping.
  always_comb begin
    int w_idx;
    w_found   = 1'b0;
    w_win_idx = '0;
    w_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_win_idx = PTR_W'(w_idx);
      end else begin
        w_found   = w_found;
      end
    end
  end

  // Grant vector; held at zero while reset is asserted so nothing is accepted.
  always_comb begin
    w_grant = '0;
    if (w_found && !reset) begin
      w_grant[w_win_idx] = 1'b1;
    end else begin
      w_grant = '0;
    end
  end

  assign w_accept   = w_found && !reset;
  assign w_win_addr = req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
  assign w_win_data = req_data[int'(w_win_idx)*DATA_W +: DATA_W];
  assign w_ptr_next = (w_win_idx == PTR_W'(NREQ-1)) ? '0 : w_win_idx + PTR_W'(1);

  // Write port and pointer: load the winner on accept, otherwise hold address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_we    <= 1'b1;
      r_waddr <= w_win_addr;
      r_wdata <= w_win_data;
      r_ptr   <= w_ptr_next;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Committed-write counter: a write commits on each edge where rf_we is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= 8'd0;
    end else if (r_we) begin
      r_wr_count <= r_wr_count + 8'd1;
    end else begin
      r_wr_count <= r_wr_count;
    end
  end

  assign req_ready = w_grant;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign wr_count  = r_wr_count;
  assign hazard1   = r_we && (r_waddr == rd_addr1);
  assign hazard2   = r_we && (r_waddr == rd_addr2);

endmodule

// File: tb/tb_rf_write_arbiter.sv
`timescale 1ns/1ps
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [8:0]  req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;
  logic        hazard1;
  logic        hazard2;
  logic [7:0]  wr_count;

  int total = 0;
  int bad   = 0;
  logic [10:0] sb[$];

  rf_write_arbiter #(.NREQ(3), .DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a write, compare against the scoreboard.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%0h data=%0h expected none at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h at %0t",
                   rf_waddr, rf_wdata, e[10:8], e[7:0], $time);
        end
      end
    end
  end

  // One cycle: present valid, check grant, queue the expected commit, advance.
  task automatic step(input logic [2:0] v, input logic [2:0] exp_rdy,
                      input logic [2:0] a, input logic [7:0] d);
    req_valid = v;
    #1;
    chk("req_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
    if (exp_rdy != 3'b000) sb.push_back({a, d});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 3'b111;
    req_addr  = 9'd0;
    req_data  = 24'd0;
    rd_addr1  = 3'd0;
    rd_addr2  = 3'd0;
    @(negedge clk);
    // Reset state
    chk("rst_we",    {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", {24'd0, rf_wdata}, 32'd0);
    chk("rst_count", {24'd0, wr_count}, 32'd0);
    chk("rst_ready", {29'd0, req_ready}, 32'd0);
    chk("rst_haz",   {30'd0, hazard1, hazard2}, 32'd0);
    reset = 1'b0;

    // Single request, signed data passes bit-exact
    req_addr = {3'd0, 3'd5, 3'd0};
    req_data = {8'h00, 8'hFD, 8'h00};
    step(3'b010, 3'b010, 3'd5, 8'hFD);
    step(3'b000, 3'b000, 3'd0, 8'h00);
    chk("single_count", {24'd0, wr_count}, 32'd1);
    chk("single_we_low", {31'd0, rf_we}, 32'd0);

    // Full contention from a fresh reset: 0,1,2,0,1,2
    reset_pulse();
    req_addr = {3'd7, 3'd2, 3'd1};
    req_data = {8'hC2, 8'hB1, 8'hA0};
    for (int r = 0; r < 2; r++) begin
      step(3'b111, 3'b001, 3'd1, 8'hA0);
      step(3'b111, 3'b010, 3'd2, 8'hB1);
      step(3'b111, 3'b100, 3'd7, 8'hC2);
    end
    step(3'b000, 3'b000, 3'd0, 8'h00);
    chk("contend_count", {24'd0, wr_count}, 32'd6);

    // Same-address collision, ptr back at 0
    req_addr = {3'd3, 3'd0, 3'd3};
    req_data = {8'h22, 8'h00, 8'h11};
    step(3'b101, 3'b001, 3'd3, 8'h11);
    step(3'b100, 3'b100, 3'd3, 8'h22);
    step(3'b000, 3'b000, 3'd0, 8'h00);
    chk("coll_waddr", {29'd0, rf_waddr}, 32'd3);
    chk("coll_wdata", {24'd0, rf_wdata}, 32'h22);
    chk("coll_count", {24'd0, wr_count}, 32'd8);

    // Hazard detection against the write in flight
    req_addr = {3'd0, 3'd0, 3'd4};
    req_data = {8'h00, 8'h00, 8'h44};
    rd_addr1 = 3'd4;
    rd_addr2 = 3'd2;
    step(3'b001, 3'b001, 3'd4, 8'h44);
    chk("haz1_hit",  {31'd0, hazard1}, 32'd1);
    chk("haz2_miss", {31'd0, hazard2}, 32'd0);
    step(3'b000, 3'b000, 3'd0, 8'h00);
    chk("haz1_idle", {31'd0, hazard1}, 32'd0);
    chk("haz2_idle", {31'd0, hazard2}, 32'd0);

    // Reset mid-write drops the uncommitted write; ptr restarts at 0
    req_addr  = {3'd0, 3'd6, 3'd1};
    req_data  = {8'h00, 8'h7F, 8'h01};
    req_valid = 3'b010;
    #1;
    chk("midrst_ready", {29'd0, req_ready}, 32'b010);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_we",    {31'd0, rf_we}, 32'd0);
    chk("midrst_count", {24'd0, wr_count}, 32'd0);
    chk("midrst_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("midrst_rdy",   {29'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(3'b011, 3'b001, 3'd1, 8'h01);
    step(3'b011, 3'b010, 3'd6, 8'h7F);
    step(3'b000, 3'b000, 3'd0, 8'h00);
    chk("postrst_count", {24'd0, wr_count}, 32'd2);

    // Counter wrap: 256 back-to-back writes from requester 0
    reset_pulse();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      req_addr = {6'd0, iv[2:0]};
      req_data = {16'd0, iv};
      step(3'b001, 3'b001, iv[2:0], iv);
    end
    chk("wrap_255", {24'd0, wr_count}, 32'd255);
    step(3'b000, 3'b000, 3'd0, 8'h00);
    chk("wrap_0", {24'd0, wr_count}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
